algn_fifo_irq_ctrl: RTL and testbench
=====================================

Name: algn_fifo_irq_ctrl

Overview:
- Parametrised FIFO-occupancy tracker and interrupt controller for the aligner. It generalises the fixed RX/TX push/pop handshake set to N_CH channels.
- It watches each channel's push/pop strobes and keeps an occupancy level. It latches sticky event flags (full, empty, overflow, underflow) and counts dropped pushes.
- It drives a single aggregated, maskable irq toward the CPU/testbench.
- Sits beside the aligner core, between the FIFO handshake strobes and the register block.

Parameters:
- N_CH, 2, number of FIFO channels (channel 0 = RX, channel 1 = TX by convention)
- DEPTH, 8, capacity of every tracked FIFO in entries (>=2)
- CNT_W, 8, width of each per-channel drop counter
- LVL_W, $clog2(DEPTH+1), width of each level field (derived, not overridden)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- push  in  N_CH  per-channel push strobe, one entry per cycle high
- pop  in  N_CH  per-channel pop strobe, one entry per cycle high
- irq_en  in  4*N_CH  interrupt enable mask; bits [4c+3:4c] belong to channel c
- irq_clr  in  4*N_CH  write-1-to-clear pulse for irq_status bits
- drop_clr  in  N_CH  pulse: zero channel drop counter
- level  out  LVL_W*N_CH  current occupancy per channel
- full  out  N_CH  level == DEPTH
- empty  out  N_CH  level == 0
- irq_status  out  4*N_CH  sticky flags per channel: bit0 full_reached, bit1 empty_reached, bit2 overflow, bit3 underflow
- drop_cnt  out  CNT_W*N_CH  overflow (dropped push) count per channel
- max_drop  out  N_CH  drop counter saturated at 2^CNT_W-1
- irq  out  1  registered OR of (irq_status & irq_en)

Behaviour:
- Reset values (reset high at clk edge): level=0, empty=all 1, full=0, irq_status=0, drop_cnt=0, max_drop=0, irq=0.
- Reset mid-operation discards all state on that edge; strobes in the reset cycle are ignored.
- Channels are independent and identical. Per channel, per cycle, with L = level:
  - push only, L<DEPTH: L+1.
  - push only, L==DEPTH: push dropped, L unchanged, overflow set, drop_cnt+1.
  - pop only, L>0: L-1.
  - pop only, L==0: pop rejected, L unchanged, underflow set.
  - push&pop, 0<L<=DEPTH: both accepted, L unchanged, no overflow even when full.
  - push&pop, L==0: push accepted, pop rejected, L=1, underflow set.
- Event detection: full_reached sets on the edge where L goes from DEPTH-1 to DEPTH. empty_reached sets on the edge where L goes from 1 to 0. Holding at a boundary does not re-set the flag.
- full, empty, level: registered, valid the cycle after the strobe (1-cycle latency).
- irq_status is sticky until cleared by irq_clr. Set has priority over clear in the same cycle; the bit stays 1.
- drop_cnt saturates at 2^CNT_W-1 and never wraps. max_drop = (drop_cnt == all ones), registered alongside.
- drop_clr zeroes the counter. If an overflow coincides with drop_clr, the result is 1.
- irq is registered each cycle as |(irq_status & irq_en), so it rises 2 cycles after the causing strobe edge.
  - Masking via irq_en takes effect on irq 1 cycle later.
  - Clearing the last enabled flag drops irq 1 cycle after the clear edge.
- All arithmetic is unsigned, LVL_W wide; level never exceeds DEPTH or goes below 0.

Test Plan:
- Reset/idle, N_CH=2, DEPTH=4, CNT_W=4: assert reset 2 cycles -> level=0/0, empty=2'b11, full=0, irq_status=0, irq=0.
- Fill ch0: 4 consecutive pushes, irq_en=8'h01 -> level0=4, full[0]=1, irq_status[0]=1 one cycle after 4th push, irq=1 one cycle later. irq_clr=8'h01 -> status 0 and irq 0 on successive cycles.
- Overflow/saturation: ch0 full, 17 further pushes with irq_en[2]=1 -> level0 stays 4, drop_cnt0 stops at 15, max_drop[0]=1, irq_status[2]=1. drop_clr[0] -> drop_cnt0=0, max_drop[0]=0.
- Simultaneous ops: ch1 at level 0, push&pop together -> level1=1, irq_status[7] (underflow) =1. Ch0 full, push&pop together -> level0=4, no overflow, drop_cnt unchanged.
- Set-vs-clear priority: ch1 pop at level 1 in the same cycle as irq_clr[5]=1 -> empty_reached (bit5) remains 1. With irq_en=0, irq stays 0; enabling bit5 raises irq 1 cycle later.
- Reset mid-fill: ch0 at level 3 with overflow flag set, reset for 1 cycle concurrent with a push -> all outputs return to reset values, the push is ignored, level0=0.

Source files
------------

// File: rtl/algn_fifo_irq_ctrl.sv
// FIFO occupancy tracker and aggregated interrupt controller for the aligner.
// Each channel follows its FIFO's push/pop strobes to keep an occupancy level.
// It also latches sticky event flags, counts dropped pushes, and drives one maskable irq.
module algn_fifo_irq_ctrl #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8,
  // Derived from DEPTH; leave at its default.
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         push,
  input  logic [N_CH-1:0]         pop,
  input  logic [4*N_CH-1:0]       irq_en,
  input  logic [4*N_CH-1:0]       irq_clr,
  input  logic [N_CH-1:0]         drop_clr,
  output logic [LVL_W*N_CH-1:0]   level,
  output logic [N_CH-1:0]         full,
  output logic [N_CH-1:0]         empty,
  output logic [4*N_CH-1:0]       irq_status,
  output logic [CNT_W*N_CH-1:0]   drop_cnt,
  output logic [N_CH-1:0]         max_drop,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LVL_W*N_CH-1:0] level_n;
  logic [N_CH-1:0]       full_n;
  logic [N_CH-1:0]       empty_n;
  logic [4*N_CH-1:0]     status_n;
  logic [CNT_W*N_CH-1:0] drop_n;
  logic [N_CH-1:0]       max_n;

  logic [LVL_W-1:0] cur;
  logic [LVL_W-1:0] nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       set;
  logic             is_full;
  logic             is_empty;
  logic             acc_push;
  logic             acc_pop;
  logic             ovf;
  logic             udf;

  // Per-channel next-state: occupancy, event flags and drop counter.
  always_comb begin
    level_n  = level;
    full_n   = full;
    empty_n  = empty;
    status_n = irq_status;
    drop_n   = drop_cnt;
    max_n    = max_drop;
    cur      = '0;
    nxt      = '0;
    cnt      = '0;
    set      = '0;
    is_full  = 1'b0;
    is_empty = 1'b0;
    acc_push = 1'b0;
    acc_pop  = 1'b0;
    ovf      = 1'b0;
    udf      = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      cur      = level[c*LVL_W +: LVL_W];
      is_full  = (cur == LVL_W'(DEPTH));
      is_empty = (cur == '0);
      // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
      acc_pop  = pop[c] && !is_empty;
      acc_push = push[c] && (!is_full || pop[c]);
      ovf      = push[c] && !pop[c] && is_full;
      udf      = pop[c] && is_empty;
      nxt      = cur + LVL_W'(acc_push) - LVL_W'(acc_pop);

      set = {udf, ovf,
             (cur == LVL_W'(1)) && (nxt == '0),
             (cur == LVL_W'(DEPTH - 1)) && (nxt == LVL_W'(DEPTH))};
      status_n[c*4 +: 4] = (irq_status[c*4 +: 4] & ~irq_clr[c*4 +: 4]) | set;

      cnt = drop_cnt[c*CNT_W +: CNT_W];
      if (ovf) begin
        if (drop_clr[c])         cnt = CNT_W'(1);
        else if (cnt != CNT_MAX) cnt = cnt + CNT_W'(1);
      end else if (drop_clr[c]) begin
        cnt = '0;
      end

      level_n[c*LVL_W +: LVL_W] = nxt;
      drop_n[c*CNT_W +: CNT_W]  = cnt;
      full_n[c]  = (nxt == LVL_W'(DEPTH));
      empty_n[c] = (nxt == '0);
      max_n[c]   = (cnt == CNT_MAX);
    end
  end

  // State registers; irq is derived from the registered flags, hence one extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      level      <= '0;
      full       <= '0;
      empty      <= '1;
      irq_status <= '0;
      drop_cnt   <= '0;
      max_drop   <= '0;
      irq        <= 1'b0;
    end else begin
      level      <= level_n;
      full       <= full_n;
      empty      <= empty_n;
      irq_status <= status_n;
      drop_cnt   <= drop_n;
      max_drop   <= max_n;
      irq        <= |(irq_status & irq_en);
    end
  end

endmodule

// File: tb/tb_algn_fifo_irq_ctrl.sv
// Scoreboard bench for algn_fifo_irq_ctrl (N_CH=2, DEPTH=4, CNT_W=4).
module tb_algn_fifo_irq_ctrl;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LVL_W = 3;

  localparam int S_LVL  = 0;
  localparam int S_FULL = 1;
  localparam int S_EMP  = 2;
  localparam int S_STAT = 3;
  localparam int S_DROP = 4;
  localparam int S_MAXD = 5;
  localparam int S_IRQ  = 6;

  typedef struct {
    int          cyc;
    int          sel;
    string       name;
    logic [31:0] val;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       push = '0;
  logic [N_CH-1:0]       pop = '0;
  logic [4*N_CH-1:0]     irq_en = '0;
  logic [4*N_CH-1:0]     irq_clr = '0;
  logic [N_CH-1:0]       drop_clr = '0;
  logic [LVL_W*N_CH-1:0] level;
  logic [N_CH-1:0]       full;
  logic [N_CH-1:0]       empty;
  logic [4*N_CH-1:0]     irq_status;
  logic [CNT_W*N_CH-1:0] drop_cnt;
  logic [N_CH-1:0]       max_drop;
  logic                  irq;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q[$];

  algn_fifo_irq_ctrl #(.N_CH(N_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .irq_en(irq_en),
    .irq_clr(irq_clr), .drop_clr(drop_clr), .level(level), .full(full),
    .empty(empty), .irq_status(irq_status), .drop_cnt(drop_cnt),
    .max_drop(max_drop), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      S_LVL:   return 32'(level);
      S_FULL:  return 32'(full);
      S_EMP:   return 32'(empty);
      S_STAT:  return 32'(irq_status);
      S_DROP:  return 32'(drop_cnt);
      S_MAXD:  return 32'(max_drop);
      default: return 32'(irq);
    endcase
  endfunction

  // Expectation for the outputs after the coming clock edge.
  task automatic ex(input int sel, input string name, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.name = name;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic drv(input logic [1:0] pu, input logic [1:0] po,
                     input logic [7:0] clr, input logic [1:0] dclr);
    push     = pu;
    pop      = po;
    irq_clr  = clr;
    drop_clr = dclr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_reset_vals();
    ex(S_LVL,  "rst_level", 0);
    ex(S_FULL, "rst_full", 0);
    ex(S_EMP,  "rst_empty", 3);
    ex(S_STAT, "rst_status", 0);
    ex(S_DROP, "rst_drop", 0);
    ex(S_MAXD, "rst_maxdrop", 0);
    ex(S_IRQ,  "rst_irq", 0);
  endtask

  // Monitor: compare every expectation due at this sample point.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc)
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      else if (dut_val(e.sel) !== e.val)
        $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", e.name, cyc, dut_val(e.sel), e.val);
      else
        passes++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges.
    tick();
    ex_reset_vals();
    tick();
    reset = 1'b0;

    // Fill channel 0 with full-reached interrupt enabled.
    irq_en = 8'h01;
    for (int n = 1; n <= 4; n++) begin
      drv(2'b01, 2'b00, 8'h00, 2'b00);
      ex(S_LVL, "fill_level", 32'(n));
      ex(S_EMP, "fill_empty", 2);
      ex(S_FULL, "fill_full", (n == 4) ? 1 : 0);
      ex(S_STAT, "fill_status", (n == 4) ? 1 : 0);
      ex(S_IRQ, "fill_irq", 0);
      tick();
    end
    drv(2'b00, 2'b00, 8'h00, 2'b00);
    ex(S_IRQ, "full_irq_rise", 1);
    tick();
    drv(2'b00, 2'b00, 8'h01, 2'b00);
    ex(S_STAT, "clr_status", 0);
    ex(S_IRQ, "clr_irq_lag", 1);
    tick();
    drv(2'b00, 2'b00, 8'h00, 2'b00);
    ex(S_IRQ, "clr_irq_drop", 0);
    tick();

    // Overflow with saturating drop counter.
    irq_en = 8'h04;
    for (int n = 1; n <= 17; n++) begin
      drv(2'b01, 2'b00, 8'h00, 2'b00);
      ex(S_LVL, "ovf_level", 4);
      ex(S_DROP, "ovf_drop", (n >= 15) ? 15 : 32'(n));
      ex(S_MAXD, "ovf_maxdrop", (n >= 15) ? 1 : 0);
      ex(S_STAT, "ovf_status", 4);
      ex(S_IRQ, "ovf_irq", (n >= 2) ? 1 : 0);
      tick();
    end
    drv(2'b00, 2'b00, 8'h00, 2'b01);
    ex(S_DROP, "dclr_drop", 0);
    ex(S_MAXD, "dclr_maxdrop", 0);
    ex(S_IRQ, "dclr_irq", 1);
    tick();
    drv(2'b01, 2'b00, 8'h00, 2'b01);
    ex(S_DROP, "dclr_ovf_drop", 1);
    tick();
    drv(2'b00, 2'b00, 8'h00, 2'b01);
    ex(S_DROP, "dclr2_drop", 0);
    tick();

    // Clear everything and mask.
    irq_en = 8'h00;
    drv(2'b00, 2'b00, 8'hFF, 2'b00);
    ex(S_STAT, "clrall_status", 0);
    ex(S_IRQ, "clrall_irq", 0);
    tick();

    // Simultaneous push&pop: ch1 empty, then ch0 full.
    drv(2'b10, 2'b10, 8'h00, 2'b00);
    ex(S_LVL, "pp_empty_level", 12);
    ex(S_EMP, "pp_empty_empty", 0);
    ex(S_STAT, "pp_empty_status", 8'h80);
    tick();
    drv(2'b01, 2'b01, 8'h00, 2'b00);
    ex(S_LVL, "pp_full_level", 12);
    ex(S_FULL, "pp_full_full", 1);
    ex(S_DROP, "pp_full_drop", 0);
    ex(S_STAT, "pp_full_status", 8'h80);
    tick();

    // Set beats clear on empty_reached.
    drv(2'b00, 2'b10, 8'h20, 2'b00);
    ex(S_LVL, "prio_level", 4);
    ex(S_EMP, "prio_empty", 2);
    ex(S_STAT, "prio_status", 8'hA0);
    ex(S_IRQ, "prio_irq", 0);
    tick();
    drv(2'b00, 2'b00, 8'h00, 2'b00);
    ex(S_IRQ, "masked_irq", 0);
    tick();
    irq_en = 8'h20;
    ex(S_IRQ, "unmask_irq", 1);
    tick();

    // Reset mid-operation: level 3 with overflow flagged, push during reset.
    drv(2'b01, 2'b00, 8'h00, 2'b00);
    ex(S_STAT, "pre_rst_status", 8'hA4);
    ex(S_DROP, "pre_rst_drop", 1);
    tick();
    drv(2'b00, 2'b01, 8'h00, 2'b00);
    ex(S_LVL, "pre_rst_level", 3);
    tick();
    reset = 1'b1;
    drv(2'b01, 2'b00, 8'h00, 2'b00);
    ex_reset_vals();
    tick();
    reset = 1'b0;
    drv(2'b00, 2'b00, 8'h00, 2'b00);
    ex(S_LVL, "post_rst_level", 0);
    ex(S_EMP, "post_rst_empty", 3);
    ex(S_IRQ, "post_rst_irq", 0);
    tick();

    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      checks++;
      $display("FAIL %s: expectation never compared", q[0].name);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
